lcd_bus_decoder: RTL and testbench

//  Listens on the HD44780-style 4-bit character-LCD bus (sf_e, e, rs, rw, 4-bit nibble) as the

---
 rtl/lcd_bus_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_lcd_bus_decoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_decoder.sv
// Panel-side decoder for the HD44780-style 4-bit character-LCD bus: rebuilds bytes, tracks controller state, emits visible character writes.
// Optional shadow screen buffer behind rd_pos/rd_data is compiled in with `define LCD_SHADOW_EN.
module lcd_bus_decoder #(
  parameter int MIN_E_HIGH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sf_e,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_db,
  output logic       byte_valid,
  output logic       byte_rs,
  output logic [7:0] byte_data,
  output logic       mode4,
  output logic [6:0] ddram_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       clear_pulse,
  output logic       char_we,
  output logic [4:0] char_pos,
  output logic [7:0] char_data,
  input  logic [4:0] rd_pos,
  output logic [7:0] rd_data
);

  typedef enum logic [1:0] {BOOT8, HI, LO} state_t;

  localparam int CW = $clog2(MIN_E_HIGH + 1);
  localparam logic [CW-1:0] HI_MAX = CW'(MIN_E_HIGH);

  // {sf_e, e, rs, rw, db[3:0]}
  logic [7:0] sync1, sync2;
  logic       s_sf, s_e, s_rs, s_rw;
  logic [3:0] s_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sf_e, lcd_e, lcd_rs, lcd_rw, lcd_db};
      sync2 <= sync1;
    end
  end

  assign {s_sf, s_e, s_rs, s_rw, s_db} = sync2;

  // hi_cnt saturates; a fall only counts once e has been high long enough.
  logic [CW-1:0] hi_cnt;
  logic          p_rs, p_rw;
  logic [3:0]    p_db;
  logic          strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt <= '0;
      p_rs   <= 1'b0;
      p_rw   <= 1'b0;
      p_db   <= '0;
    end else begin
      if (!s_e)                hi_cnt <= '0;
      else if (hi_cnt < HI_MAX) hi_cnt <= hi_cnt + 1'b1;
      p_rs <= s_rs;
      p_rw <= s_rw;
      p_db <= s_db;
    end
  end

  assign strobe = !s_e && (hi_cnt == HI_MAX) && s_sf;

  // 2-line DDRAM map: line0 0x00-0x27, line1 0x40-0x67, wrapping between them.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h40)      r = 7'h27;
      else if (a == 7'h00) r = 7'h67;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  state_t     state, nxt_state;
  logic [3:0] hold, nxt_hold;
  logic [6:0] nxt_addr;
  logic       id, nxt_id, cg, nxt_cg;
  logic       nxt_disp, nxt_cur, nxt_blink;
  logic       nxt_bv, nxt_brs, nxt_clr, nxt_we;
  logic [7:0] nxt_bdata, nxt_cdata, cmd;
  logic [4:0] nxt_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT8;
      hold        <= '0;
      ddram_addr  <= '0;
      id          <= 1'b1;
      cg          <= 1'b0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      byte_valid  <= 1'b0;
      byte_rs     <= 1'b0;
      byte_data   <= '0;
      clear_pulse <= 1'b0;
      char_we     <= 1'b0;
      char_pos    <= '0;
      char_data   <= '0;
    end else begin
      state       <= nxt_state;
      hold        <= nxt_hold;
      ddram_addr  <= nxt_addr;
      id          <= nxt_id;
      cg          <= nxt_cg;
      disp_on     <= nxt_disp;
      cursor_on   <= nxt_cur;
      blink_on    <= nxt_blink;
      byte_valid  <= nxt_bv;
      byte_rs     <= nxt_brs;
      byte_data   <= nxt_bdata;
      clear_pulse <= nxt_clr;
      char_we     <= nxt_we;
      char_pos    <= nxt_pos;
      char_data   <= nxt_cdata;
    end
  end

  assign mode4 = (state != BOOT8);
  assign cmd   = {hold, p_db};

  always_comb begin
    nxt_state = state;
    nxt_hold  = hold;
    nxt_addr  = ddram_addr;
    nxt_id    = id;
    nxt_cg    = cg;
    nxt_disp  = disp_on;
    nxt_cur   = cursor_on;
    nxt_blink = blink_on;
    nxt_bv    = 1'b0;
    nxt_brs   = byte_rs;
    nxt_bdata = byte_data;
    nxt_clr   = 1'b0;
    nxt_we    = 1'b0;
    nxt_pos   = char_pos;
    nxt_cdata = char_data;
    if (strobe) begin
      case (state)
        BOOT8: if (!p_rs && !p_rw && p_db == 4'h2) nxt_state = HI;
        HI: begin
          nxt_hold  = p_db;
          nxt_state = LO;
        end
        LO: begin
          nxt_state = HI;
          // Reads still consume a phase, so they realign the nibble pairing.
          if (!p_rw) begin
            nxt_bv    = 1'b1;
            nxt_brs   = p_rs;
            nxt_bdata = cmd;
            if (p_rs) begin
              if (!cg) begin
                if (ddram_addr[5:4] == 2'b00) begin
                  nxt_we    = 1'b1;
                  nxt_pos   = {ddram_addr[6], ddram_addr[3:0]};
                  nxt_cdata = cmd;
                end
                nxt_addr = addr_step(ddram_addr, id);
              end
            end else begin
              if (cmd[7]) begin
                nxt_addr = cmd[6:0];
                nxt_cg   = 1'b0;
              end else if (cmd[6]) begin
                nxt_cg = 1'b1;
              end else if (cmd[5]) begin
                if (cmd[4]) nxt_state = BOOT8;
              end else if (cmd[4]) begin
                if (!cmd[3]) nxt_addr = addr_step(ddram_addr, cmd[2]);
              end else if (cmd[3]) begin
                {nxt_disp, nxt_cur, nxt_blink} = cmd[2:0];
              end else if (cmd[2]) begin
                nxt_id = cmd[1];
              end else if (cmd[1]) begin
                nxt_addr = '0;
              end else if (cmd[0]) begin
                nxt_addr = '0;
                nxt_id   = 1'b1;
                nxt_clr  = 1'b1;
              end
            end
          end
        end
        default: nxt_state = BOOT8;
      endcase
    end
  end

`ifdef LCD_SHADOW_EN
  logic [7:0] scr [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) scr[i] <= 8'h20;
      rd_data <= 8'h20;
    end else begin
      if (nxt_clr) begin
        for (int i = 0; i < 32; i++) scr[i] <= 8'h20;
      end else if (nxt_we) begin
        scr[nxt_pos] <= nxt_cdata;
      end
      rd_data <= scr[rd_pos];
    end
  end
`else
  logic unused_rd_pos;
  assign unused_rd_pos = ^rd_pos;
  assign rd_data       = 8'h20;
`endif

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Bench for lcd_bus_decoder: command table, hand-written corner sequences and random traffic against a line/column screen model.
module tb_lcd_bus_decoder;
  localparam int MINH = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic sf_e = 1'b0, lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [3:0] lcd_db = '0;
  logic [4:0] rd_pos = '0;
  logic byte_valid, byte_rs, mode4, disp_on, cursor_on, blink_on, clear_pulse, char_we;
  logic [7:0] byte_data, char_data, rd_data;
  logic [6:0] ddram_addr;
  logic [4:0] char_pos;

  lcd_bus_decoder #(.MIN_E_HIGH(MINH)) dut (
    .clk(clk), .rst_n(rst_n), .sf_e(sf_e), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db(lcd_db), .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data),
    .mode4(mode4), .ddram_addr(ddram_addr), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .clear_pulse(clear_pulse), .char_we(char_we), .char_pos(char_pos),
    .char_data(char_data), .rd_pos(rd_pos), .rd_data(rd_data));

  always #10 clk = ~clk;

  int n_checks = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse monitor: the only writer of these queues/counters.
  logic [8:0]  dq_b[$];
  logic [12:0] dq_c[$];
  int d_clr = 0, n_we = 0;
  always @(negedge clk) if (rst_n) begin
    if (byte_valid) dq_b.push_back({byte_rs, byte_data});
    if (char_we) begin
      dq_c.push_back({char_pos, char_data});
      n_we++;
    end
    if (clear_pulse) d_clr++;
  end
  int rd_b = 0, rd_c = 0;

  // Reference model: cursor kept as (line, column 0..39), not as a raw address.
  bit m_mode4, m_lo, m_id, m_cg;
  logic [3:0] m_hold;
  logic [2:0] m_dcb;
  int m_line, m_col, e_clr = 0;
  logic [7:0] m_scr[32];
  logic [8:0]  eq_b[$];
  logic [12:0] eq_c[$];

  function automatic logic [6:0] m_addr();
    return 7'(m_line * 64 + m_col);
  endfunction

  task automatic m_reset();
    m_mode4 = 0; m_lo = 0; m_id = 1; m_cg = 0; m_dcb = '0; m_line = 0; m_col = 0;
    for (int i = 0; i < 32; i++) m_scr[i] = 8'h20;
  endtask

  task automatic m_move(input bit inc);
    if (inc) begin
      m_col++;
      if (m_col == 40) begin m_col = 0; m_line = 1 - m_line; end
    end else begin
      m_col--;
      if (m_col < 0) begin m_col = 39; m_line = 1 - m_line; end
    end
  endtask

  task automatic m_byte(input bit rs, input logic [7:0] b);
    eq_b.push_back({rs, b});
    if (rs) begin
      if (!m_cg) begin
        if (m_col < 16) begin
          eq_c.push_back({1'(m_line), 4'(m_col), b});
          m_scr[m_line * 16 + m_col] = b;
        end
        m_move(m_id);
      end
    end else if (b[7]) begin
      m_line = int'(b[6]); m_col = int'(b[5:0]); m_cg = 0;
    end else if (b[6]) m_cg = 1;
    else if (b[5]) begin
      if (b[4]) m_mode4 = 0;
    end else if (b[4]) begin
      if (!b[3]) m_move(b[2]);
    end else if (b[3]) m_dcb = b[2:0];
    else if (b[2]) m_id = b[1];
    else if (b[1]) begin m_line = 0; m_col = 0; end
    else if (b[0]) begin
      m_line = 0; m_col = 0; m_id = 1; e_clr++;
      for (int i = 0; i < 32; i++) m_scr[i] = 8'h20;
    end
  endtask

  task automatic m_strobe(input bit rs, input bit rw, input logic [3:0] nib);
    if (!m_mode4) begin
      if (!rs && !rw && nib == 4'h2) begin m_mode4 = 1; m_lo = 0; end
    end else if (!m_lo) begin
      m_hold = nib; m_lo = 1;
    end else begin
      m_lo = 0;
      if (!rw) m_byte(rs, {m_hold, nib});
    end
  endtask

  task automatic check_model();
    logic [8:0] eb;
    logic [12:0] ec;
    while (eq_b.size() > 0) begin
      eb = eq_b.pop_front();
      if (rd_b < dq_b.size()) begin chk("byte", 32'(dq_b[rd_b]), 32'(eb)); rd_b++; end
      else chk("byte_missing", 32'(0), 32'(eb));
    end
    chk("byte_extra", 32'(dq_b.size() - rd_b), 32'(0));
    rd_b = dq_b.size();
    while (eq_c.size() > 0) begin
      ec = eq_c.pop_front();
      if (rd_c < dq_c.size()) begin chk("char", 32'(dq_c[rd_c]), 32'(ec)); rd_c++; end
      else chk("char_missing", 32'(0), 32'(ec));
    end
    chk("char_extra", 32'(dq_c.size() - rd_c), 32'(0));
    rd_c = dq_c.size();
    chk("clear_cnt", 32'(d_clr), 32'(e_clr));
    chk("ddram_addr", 32'(ddram_addr), 32'(m_addr()));
    chk("dcb", 32'({disp_on, cursor_on, blink_on}), 32'(m_dcb));
    chk("mode4", 32'(mode4), 32'(m_mode4));
  endtask

  task automatic check_rd(input logic [4:0] p);
    logic [7:0] exp;
    @(negedge clk); rd_pos = p;
    repeat (2) @(negedge clk);
`ifdef LCD_SHADOW_EN
    exp = m_scr[p];
`else
    exp = 8'h20;
`endif
    chk("rd_data", 32'(rd_data), 32'(exp));
  endtask

  task automatic send_nib(input bit rs, input bit rw, input logic [3:0] nib, input bit sf, input int hi);
    @(negedge clk); lcd_rs = rs; lcd_rw = rw; lcd_db = nib; sf_e = sf;
    @(negedge clk); lcd_e = 1'b1;
    repeat (hi) @(negedge clk);
    lcd_e = 1'b0;
    repeat (6) @(negedge clk);
    sf_e = 1'b1;
    if (sf && hi >= MINH) m_strobe(rs, rw, nib);
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    send_nib(rs, 1'b0, b[7:4], 1'b1, 6);
    send_nib(rs, 1'b0, b[3:0], 1'b1, 6);
  endtask

  typedef struct {
    bit rs; logic [7:0] b; logic [6:0] addr; logic [2:0] dcb; bit we; logic [4:0] pos;
  } vec_t;
  vec_t tbl[20];

  initial begin
    int wb, r, ln, cl;
    logic [7:0] b;
    tbl[0]  = '{0, 8'h0C, 7'h00, 3'b100, 0, 5'd0};
    tbl[1]  = '{1, 8'h43, 7'h01, 3'b100, 1, 5'd0};
    tbl[2]  = '{0, 8'hC0, 7'h40, 3'b100, 0, 5'd0};
    tbl[3]  = '{1, 8'h4F, 7'h41, 3'b100, 1, 5'd16};
    tbl[4]  = '{0, 8'h0F, 7'h41, 3'b111, 0, 5'd0};
    tbl[5]  = '{0, 8'h10, 7'h40, 3'b111, 0, 5'd0};
    tbl[6]  = '{0, 8'h14, 7'h41, 3'b111, 0, 5'd0};
    tbl[7]  = '{0, 8'hA7, 7'h27, 3'b111, 0, 5'd0};
    tbl[8]  = '{1, 8'h41, 7'h40, 3'b111, 0, 5'd0};
    tbl[9]  = '{0, 8'h04, 7'h40, 3'b111, 0, 5'd0};
    tbl[10] = '{0, 8'h80, 7'h00, 3'b111, 0, 5'd0};
    tbl[11] = '{1, 8'h58, 7'h67, 3'b111, 1, 5'd0};
    tbl[12] = '{0, 8'h02, 7'h00, 3'b111, 0, 5'd0};
    tbl[13] = '{0, 8'h06, 7'h00, 3'b111, 0, 5'd0};
    tbl[14] = '{0, 8'h8F, 7'h0F, 3'b111, 0, 5'd0};
    tbl[15] = '{1, 8'h5A, 7'h10, 3'b111, 1, 5'd15};
    tbl[16] = '{0, 8'hE7, 7'h67, 3'b111, 0, 5'd0};
    tbl[17] = '{1, 8'h20, 7'h00, 3'b111, 0, 5'd0};
    tbl[18] = '{0, 8'h01, 7'h00, 3'b111, 0, 5'd0};
    tbl[19] = '{0, 8'h08, 7'h00, 3'b000, 0, 5'd0};

    // Reset state
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_byte_valid", 32'(byte_valid), 32'(0));
    chk("rst_mode4", 32'(mode4), 32'(0));
    chk("rst_addr", 32'(ddram_addr), 32'(0));
    chk("rst_dcb", 32'({disp_on, cursor_on, blink_on}), 32'(0));
    chk("rst_pulses", 32'({char_we, clear_pulse}), 32'(0));
    chk("rst_data", 32'({byte_rs, byte_data, char_pos, char_data}), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(8'h20));
    rst_n = 1'b1;

    // Boot: 3,3,3,2 enters 4-bit mode without producing a byte
    send_nib(0, 0, 4'h3, 1, 6); send_nib(0, 0, 4'h3, 1, 6); send_nib(0, 0, 4'h3, 1, 6);
    chk("boot_mode4_before", 32'(mode4), 32'(0));
    send_nib(0, 0, 4'h2, 1, 6);
    chk("boot_mode4_after", 32'(mode4), 32'(1));
    check_model();

    send_byte(0, 8'h28);
    chk("t2_byte_data", 32'({byte_rs, byte_data}), 32'({1'b0, 8'h28}));
    send_byte(0, 8'h01); send_byte(0, 8'h06);
    check_model();

    // Command table
    foreach (tbl[i]) begin
      wb = n_we;
      send_byte(tbl[i].rs, tbl[i].b);
      chk($sformatf("tbl%0d_addr", i), 32'(ddram_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_dcb", i), 32'({disp_on, cursor_on, blink_on}), 32'(tbl[i].dcb));
      chk($sformatf("tbl%0d_we", i), 32'(n_we - wb), 32'(tbl[i].we));
      if (tbl[i].we) chk($sformatf("tbl%0d_pos", i), 32'({char_pos, char_data}), 32'({tbl[i].pos, tbl[i].b}));
      check_model();
    end

    // Pulse-width boundary, ignored sf_e=0 strobe, and read realigning the pairing
    send_nib(1, 0, 4'h4, 1, 6);
    send_nib(1, 0, 4'h9, 1, 2);
    send_nib(1, 0, 4'h9, 1, 3);
    send_nib(1, 0, 4'h9, 0, 6);
    send_nib(1, 1, 4'h7, 1, 4);
    send_nib(1, 0, 4'h4, 1, 6);
    send_nib(1, 0, 4'h1, 1, 6);
    chk("pair_byte_data", 32'(byte_data), 32'(8'h41));
    check_model();

    // Random traffic
    repeat (120) begin
      if (!m_mode4) send_nib(0, 0, 4'h2, 1, 6);
      r = $urandom_range(0, 9);
      case (r)
        3: begin
          ln = $urandom_range(0, 1); cl = $urandom_range(0, 39);
          b = 8'(8'h80 + ln * 64 + cl);
          send_byte(0, b);
        end
        4: send_byte(0, 8'(8'h10 + $urandom_range(0, 15)));
        5: send_byte(0, 8'(8'h04 + $urandom_range(0, 3)));
        6: send_byte(0, 8'(8'h08 + $urandom_range(0, 7)));
        7: send_byte(0, ($urandom_range(0, 7) == 0) ? 8'h30 : 8'(8'h20 + $urandom_range(0, 15)));
        8: begin
          r = $urandom_range(0, 3);
          send_byte(0, (r == 0) ? 8'(8'h40 + $urandom_range(0, 63)) : (r == 1) ? 8'h01 : 8'h02);
        end
        9: begin
          send_nib(0, 1, 4'(($urandom_range(0, 15))), 1, 5);
          send_nib(1, 1, 4'(($urandom_range(0, 15))), 1, 5);
          send_byte(1, 8'(($urandom_range(32, 126))));
        end
        default: send_byte(1, 8'(($urandom_range(32, 126))));
      endcase
      check_model();
      check_rd(5'(($urandom_range(0, 31))));
    end

    // Reset with a high nibble held, then latency of the first post-reset character
    if (!m_mode4) send_nib(0, 0, 4'h2, 1, 6);
    send_byte(0, 8'h80);
    if (m_lo) send_nib(1, 1, 4'h0, 1, 6);
    send_nib(1, 0, 4'h5, 1, 6);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("rst2_mode4", 32'(mode4), 32'(0));
    chk("rst2_addr", 32'(ddram_addr), 32'(0));
    chk("rst2_rd", 32'(rd_data), 32'(8'h20));
    m_reset();
    @(negedge clk); rst_n = 1'b1;
    send_nib(0, 0, 4'h2, 1, 6);
    check_rd(5'd0);
    send_nib(1, 0, 4'h4, 1, 6);
    @(negedge clk); lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_db = 4'h3;
    @(negedge clk); lcd_e = 1'b1;
    repeat (6) @(negedge clk);
    lcd_e = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("lat_edge2", 32'(byte_valid), 32'(0));
    @(posedge clk); #1;
    chk("lat_edge3", 32'({byte_valid, char_we}), 32'(2'b11));
    chk("lat_char", 32'({char_pos, char_data}), 32'({5'd0, 8'h43}));
    @(posedge clk); #1;
    chk("lat_edge4", 32'(byte_valid), 32'(0));
    repeat (4) @(negedge clk);
    m_strobe(1, 0, 4'h3);
    check_model();
    check_rd(5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
